// File: rtl/mem_access_ctrl.sv
// Multi-cycle data-memory access unit for the MEM stage.
// Turns a load/store request into a registered req/ack bus transaction.
// Handles wait states, misalignment, bus errors and timeouts, and returns
// big-endian lane-extracted, sign/zero-extended load data.
module mem_access_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [4:0]          req_wd,
  output logic                stall_req,
  output logic                resp_valid,
  output logic                resp_wreg,
  output logic [4:0]          resp_wd,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                excp_valid,
  output logic [1:0]          excp_code,
  output logic [ADDR_W-1:0]   fault_addr,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_sel,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic                bus_err,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OB    = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RESP, FAULT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        code_nxt;
  logic [CNT_W-1:0]  cnt;

  logic              acc_we;
  logic [1:0]        acc_size;
  logic              acc_signed;
  logic [OB-1:0]     acc_off;
  logic [4:0]        acc_wd;
  logic [NB-1:0]     acc_sel;
  logic [DATA_W-1:0] load_data;
  logic [1:0]        err_code;
  logic [ADDR_W-1:0] err_addr;

  // Access width in bytes, never wider than the bus.
  function automatic int access_bytes(input logic [1:0] size);
    int sb;
    sb = 1 << size;
    if (sb > NB) sb = NB;
    return sb;
  endfunction

  // An access must sit on a multiple of its own size; dword needs a 64-bit bus.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] low);
    logic [2:0] mask;
    mask = 3'((4'd1 << size) - 4'd1);
    if (size == 2'd3 && DATA_W == 32) return 1'b1;
    return (low & mask) != 3'd0;
  endfunction

  // Big-endian: byte offset o lives on lane NB-1-o.
  function automatic logic [NB-1:0] lane_sel(input logic [1:0] size, input logic [OB-1:0] off);
    logic [NB-1:0] sel;
    int sb, hi, lo;
    sb  = access_bytes(size);
    hi  = NB - 1 - int'(off);
    lo  = NB - int'(off) - sb;
    sel = '0;
    for (int i = 0; i < NB; i++)
      if (i <= hi && i >= lo) sel[i] = 1'b1;
    return sel;
  endfunction

  // Low size_bytes of store data copied onto every lane group.
  function automatic logic [DATA_W-1:0] replicate(input logic [1:0] size, input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] r;
    int sb;
    sb = access_bytes(size);
    r  = '0;
    for (int i = 0; i < NB; i++)
      r[8*i +: 8] = wdata[8*(i % sb) +: 8];
    return r;
  endfunction

  // Right-align the selected lanes and extend to the full width.
  function automatic logic [DATA_W-1:0] extract(input logic [1:0] size, input logic sgn,
                                                input logic [OB-1:0] off, input logic [DATA_W-1:0] rdata);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] r;
    int sb, lo;
    sb = access_bytes(size);
    lo = NB - int'(off) - sb;
    if (lo < 0) lo = 0;
    sh = rdata >> (8 * lo);
    r  = '0;
    for (int i = 0; i < DATA_W; i++)
      if (i < 8 * sb) r[i] = sh[i];
      else            r[i] = sgn & sh[8*sb-1];
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; error beats ack, ack beats timeout.
  always_comb begin
    state_nxt = state;
    code_nxt  = 2'd0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (is_misaligned(req_size, req_addr[2:0])) begin
            state_nxt = FAULT;
            code_nxt  = 2'd1;
          end else begin
            state_nxt = BUS;
          end
        end
      end
      BUS: begin
        if (bus_err) begin
          state_nxt = FAULT;
          code_nxt  = 2'd2;
        end else if (bus_ack) begin
          state_nxt = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nxt = FAULT;
          code_nxt  = 2'd3;
        end
      end
      RESP:    state_nxt = IDLE;
      FAULT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, wait-state counter and load-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      acc_we     <= 1'b0;
      acc_size   <= 2'd0;
      acc_signed <= 1'b0;
      acc_off    <= '0;
      acc_wd     <= 5'd0;
      acc_sel    <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      load_data  <= '0;
      err_code   <= 2'd0;
      err_addr   <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        acc_we     <= req_we;
        acc_size   <= req_size;
        acc_signed <= req_signed;
        acc_off    <= req_addr[OB-1:0];
        acc_wd     <= req_wd;
        acc_sel    <= lane_sel(req_size, req_addr[OB-1:0]);
        bus_addr   <= req_addr & ~ADDR_W'(NB - 1);
        bus_wdata  <= replicate(req_size, req_wdata);
        err_addr   <= req_addr;
      end
      if (state == BUS) begin
        if (state_nxt == BUS) cnt <= cnt + CNT_W'(1);
        else                  cnt <= '0;
        if (bus_ack && !bus_err)
          load_data <= acc_we ? '0 : extract(acc_size, acc_signed, acc_off, bus_rdata);
      end
      if (state_nxt == FAULT) err_code <= code_nxt;
    end
  end

  // Outputs decoded from state; pulse fields are zero outside their cycle.
  always_comb begin
    stall_req  = 1'b0;
    resp_valid = 1'b0;
    resp_wreg  = 1'b0;
    resp_wd    = 5'd0;
    resp_rdata = '0;
    excp_valid = 1'b0;
    excp_code  = 2'd0;
    fault_addr = '0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_sel    = '0;
    case (state)
      IDLE: stall_req = req_valid;
      BUS: begin
        stall_req = 1'b1;
        bus_req   = 1'b1;
        bus_we    = acc_we;
        bus_sel   = acc_sel;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_wreg  = !acc_we;
        resp_wd    = acc_wd;
        resp_rdata = load_data;
      end
      FAULT: begin
        excp_valid = 1'b1;
        excp_code  = err_code;
        fault_addr = err_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a 32-bit and a 64-bit instance share stimulus,
// only the selected one sees req_valid.
module tb_mem_access_ctrl;

  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        use64;
  logic        req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [4:0]  req_wd;
  logic        bus_ack, bus_err;
  logic [63:0] bus_rdata;

  logic        rv32, rv64;
  assign rv32 = req_valid & ~use64;
  assign rv64 = req_valid & use64;

  logic        a_stall, a_rv, a_rw, a_ev, a_breq, a_bwe;
  logic [4:0]  a_rwd;
  logic [1:0]  a_code;
  logic [31:0] a_rdata, a_faddr, a_baddr, a_bwdata;
  logic [3:0]  a_sel;

  logic        b_stall, b_rv, b_rw, b_ev, b_breq, b_bwe;
  logic [4:0]  b_rwd;
  logic [1:0]  b_code;
  logic [63:0] b_rdata, b_bwdata;
  logic [31:0] b_faddr, b_baddr;
  logic [7:0]  b_sel;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO)) u32 (
    .clk(clk), .rst(rst), .req_valid(rv32), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_wd(req_wd),
    .stall_req(a_stall), .resp_valid(a_rv), .resp_wreg(a_rw), .resp_wd(a_rwd), .resp_rdata(a_rdata),
    .excp_valid(a_ev), .excp_code(a_code), .fault_addr(a_faddr),
    .bus_req(a_breq), .bus_we(a_bwe), .bus_addr(a_baddr), .bus_sel(a_sel), .bus_wdata(a_bwdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata[31:0])
  );

  mem_access_ctrl #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TMO)) u64 (
    .clk(clk), .rst(rst), .req_valid(rv64), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .req_wd(req_wd),
    .stall_req(b_stall), .resp_valid(b_rv), .resp_wreg(b_rw), .resp_wd(b_rwd), .resp_rdata(b_rdata),
    .excp_valid(b_ev), .excp_code(b_code), .fault_addr(b_faddr),
    .bus_req(b_breq), .bus_we(b_bwe), .bus_addr(b_baddr), .bus_sel(b_sel), .bus_wdata(b_bwdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  logic        o_stall, o_rv, o_rw, o_ev, o_breq, o_bwe;
  logic [4:0]  o_rwd;
  logic [1:0]  o_code;
  logic [63:0] o_rdata, o_bwdata;
  logic [31:0] o_faddr, o_baddr;
  logic [7:0]  o_sel;

  // View of whichever instance is currently selected.
  always_comb begin
    if (use64) begin
      o_stall = b_stall; o_rv = b_rv; o_rw = b_rw; o_ev = b_ev; o_breq = b_breq; o_bwe = b_bwe;
      o_rwd = b_rwd; o_code = b_code; o_rdata = b_rdata; o_bwdata = b_bwdata;
      o_faddr = b_faddr; o_baddr = b_baddr; o_sel = b_sel;
    end else begin
      o_stall = a_stall; o_rv = a_rv; o_rw = a_rw; o_ev = a_ev; o_breq = a_breq; o_bwe = a_bwe;
      o_rwd = a_rwd; o_code = a_code; o_rdata = {32'd0, a_rdata}; o_bwdata = {32'd0, a_bwdata};
      o_faddr = a_faddr; o_baddr = a_baddr; o_sel = {4'd0, a_sel};
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Observations from the most recent transaction.
  int          ob_bus, ob_stall, ob_resp, ob_excp;
  bit          ob_unstable, ob_leak, ob_hung, ob_bwe, ob_wreg;
  logic [1:0]  ob_code;
  logic [31:0] ob_faddr, ob_baddr;
  logic [7:0]  ob_sel;
  logic [63:0] ob_bwdata, ob_rdata;
  logic [4:0]  ob_wd;

  task automatic run_txn(input bit w, input bit we, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                         input logic [4:0] wd, input int ack_at, input bit err);
    bit done;
    use64 = w; req_we = we; req_size = size; req_signed = sgn; req_addr = addr;
    req_wdata = wdata; req_wd = wd; bus_rdata = rdata; bus_ack = 1'b0; bus_err = 1'b0;
    req_valid = 1'b1;
    ob_bus = 0; ob_stall = 0; ob_resp = 0; ob_excp = 0; ob_unstable = 0; ob_leak = 0;
    ob_code = 0; ob_faddr = 0; ob_baddr = 0; ob_sel = 0; ob_bwdata = 0; ob_rdata = 0;
    ob_wd = 0; ob_bwe = 0; ob_wreg = 0;
    done = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (o_stall) ob_stall++;
      if (o_breq) begin
        if (ob_bus == 0) begin
          ob_baddr = o_baddr; ob_sel = o_sel; ob_bwdata = o_bwdata; ob_bwe = o_bwe;
        end else if (o_baddr !== ob_baddr || o_sel !== ob_sel || o_bwdata !== ob_bwdata || o_bwe !== ob_bwe) begin
          ob_unstable = 1;
        end
        ob_bus++;
        if (ob_bus == ack_at) begin bus_ack = 1'b1; bus_err = err; end
      end
      if (!o_rv && (o_rw || o_rwd != 0 || o_rdata != 0)) ob_leak = 1;
      if (!o_ev && o_code != 0) ob_leak = 1;
      if (o_rv) begin ob_resp++; ob_wreg = o_rw; ob_wd = o_rwd; ob_rdata = o_rdata; end
      if (o_ev) begin ob_excp++; ob_code = o_code; ob_faddr = o_faddr; end
      if (o_rv || o_ev) begin
        req_valid = 1'b0;
        done = 1;
        break;
      end
      @(negedge clk);
      bus_ack = 1'b0; bus_err = 1'b0;
    end
    ob_hung = !done;
    req_valid = 1'b0;
    @(negedge clk);
    bus_ack = 1'b0; bus_err = 1'b0;
    #1;
    if (o_rv || o_ev || o_stall || o_breq || o_code != 0 || o_rdata != 0) ob_leak = 1;
  endtask

  task automatic compare_obs(input string tag, input bit we, input logic [31:0] addr, input logic [4:0] wd,
                             input int e_bus, input int e_stall, input int e_code,
                             input logic [31:0] e_baddr, input logic [7:0] e_sel,
                             input logic [63:0] e_wdata, input logic [63:0] e_rdata, input bit e_resp);
    check({tag, ".done"},     64'(ob_hung), 64'd0);
    check({tag, ".bus_cyc"},  64'(ob_bus), 64'(e_bus));
    check({tag, ".stall_cyc"}, 64'(ob_stall), 64'(e_stall));
    check({tag, ".resp_cnt"}, 64'(ob_resp), 64'(e_resp));
    check({tag, ".excp_cnt"}, 64'(ob_excp), 64'(e_code != 0));
    check({tag, ".leak"},     64'(ob_leak), 64'd0);
    if (e_code != 0) begin
      check({tag, ".code"},  64'(ob_code), 64'(e_code));
      check({tag, ".faddr"}, 64'(ob_faddr), 64'(addr));
    end
    if (e_resp) begin
      check({tag, ".wreg"},  64'(ob_wreg), 64'(!we));
      check({tag, ".wd"},    64'(ob_wd), 64'(wd));
      check({tag, ".rdata"}, ob_rdata, e_rdata);
    end
    if (e_bus > 0) begin
      check({tag, ".baddr"},  64'(ob_baddr), 64'(e_baddr));
      check({tag, ".sel"},    64'(ob_sel), 64'(e_sel));
      check({tag, ".bwe"},    64'(ob_bwe), 64'(we));
      check({tag, ".stable"}, 64'(ob_unstable), 64'd0);
      if (we) check({tag, ".bwdata"}, ob_bwdata, e_wdata);
    end
  endtask

  // Reference model: works on byte addresses and whole access widths.
  task automatic model(input bit w, input bit we, input logic [1:0] size, input bit sgn,
                       input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                       input int ack_at, input bit err,
                       output int e_bus, output int e_stall, output int e_code,
                       output logic [31:0] e_baddr, output logic [7:0] e_sel,
                       output logic [63:0] e_wdata, output logic [63:0] e_rdata, output bit e_resp);
    int nb, sb, o;
    logic [63:0] chunk, val;
    nb = w ? 8 : 4;
    sb = 1 << size;
    e_sel = 0; e_wdata = 0; e_rdata = 0;
    e_baddr = addr - (addr % nb);
    if (sb > nb || (addr % sb) != 0) begin
      e_bus = 0; e_stall = 1; e_code = 1; e_resp = 0;
      return;
    end
    o = int'(addr % nb);
    for (int j = 0; j < sb; j++) e_sel[nb-1-(o+j)] = 1'b1;
    chunk = (sb == 8) ? wdata : (wdata & ((64'd1 << (8*sb)) - 64'd1));
    for (int r = 0; r < nb / sb; r++) e_wdata = e_wdata | (chunk << (8*sb*r));
    val = 0;
    for (int j = 0; j < sb; j++) val = (val << 8) | ((rdata >> (8*(nb-1-(o+j)))) & 64'hFF);
    if (sgn && sb < 8 && val[8*sb-1]) val = val | ~((64'd1 << (8*sb)) - 64'd1);
    if (nb == 4) val = val & 64'hFFFF_FFFF;
    if (ack_at >= 1 && ack_at <= TMO) begin
      e_bus = ack_at; e_stall = ack_at + 1; e_code = err ? 2 : 0; e_resp = !err;
    end else begin
      e_bus = TMO; e_stall = TMO + 1; e_code = 3; e_resp = 0;
    end
    e_rdata = (e_resp && !we) ? val : 64'd0;
  endtask

  typedef struct {
    bit          w64;
    bit          we;
    bit [1:0]    size;
    bit          sgn;
    bit [31:0]   addr;
    bit [63:0]   wdata;
    bit [63:0]   rdata;
    int          ack_at;
    bit          err;
    int          e_bus;
    int          e_stall;
    int          e_code;
    bit [31:0]   e_baddr;
    bit [7:0]    e_sel;
    bit [63:0]   e_wdata;
    bit [63:0]   e_rdata;
    bit          e_resp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int          e_bus, e_stall, e_code, ack_at, sb, quiet;
    logic [31:0] e_baddr, addr;
    logic [7:0]  e_sel;
    logic [63:0] e_wdata, e_rdata, wdata, rdata;
    bit          e_resp, w, we, sgn, err;
    logic [1:0]  size;
    logic [4:0]  wd;

    tbl[0] = '{0, 0, 2'd0, 1, 32'h101,  64'h0, 64'h11823344, 4, 0, 4, 5, 0, 32'h100, 8'h04, 64'h0, 64'hFFFFFF82, 1};
    tbl[1] = '{0, 1, 2'd1, 0, 32'h202,  64'h0000ABCD, 64'h0, 1, 0, 1, 2, 0, 32'h200, 8'h03, 64'hABCDABCD, 64'h0, 1};
    tbl[2] = '{0, 0, 2'd2, 0, 32'h1002, 64'h0, 64'h0, 1, 0, 0, 1, 1, 32'h0, 8'h00, 64'h0, 64'h0, 0};
    tbl[3] = '{0, 0, 2'd2, 0, 32'h300,  64'h0, 64'h0, 0, 0, 8, 9, 3, 32'h300, 8'h0F, 64'h0, 64'h0, 0};
    tbl[4] = '{0, 0, 2'd2, 0, 32'h400,  64'h0, 64'h0, 2, 1, 2, 3, 2, 32'h400, 8'h0F, 64'h0, 64'h0, 0};
    tbl[5] = '{1, 0, 2'd2, 0, 32'h104,  64'h0, 64'h0123456789ABCDEF, 2, 0, 2, 3, 0, 32'h100, 8'h0F, 64'h0, 64'h0000000089ABCDEF, 1};
    tbl[6] = '{1, 0, 2'd2, 1, 32'h100,  64'h0, 64'h89ABCDEF01234567, 3, 0, 3, 4, 0, 32'h100, 8'hF0, 64'h0, 64'hFFFFFFFF89ABCDEF, 1};
    tbl[7] = '{0, 0, 2'd3, 0, 32'h0,    64'h0, 64'h0, 1, 0, 0, 1, 1, 32'h0, 8'h00, 64'h0, 64'h0, 0};
    tbl[8] = '{0, 0, 2'd0, 0, 32'h3,    64'h0, 64'h000000A5, 8, 0, 8, 9, 0, 32'h0, 8'h01, 64'h0, 64'hA5, 1};
    tbl[9] = '{1, 1, 2'd3, 0, 32'h8,    64'h1122334455667788, 64'h0, 1, 0, 1, 2, 0, 32'h8, 8'hFF, 64'h1122334455667788, 64'h0, 1};

    rst = 1'b1; use64 = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 64'd0; req_wd = 5'd0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 64'd0;
    repeat (3) @(negedge clk);
    #1;
    check("reset.ctl32", 64'({a_stall, a_rv, a_rw, a_ev, a_breq, a_bwe}), 64'd0);
    check("reset.dat32", 64'(a_rwd) | 64'(a_code) | 64'(a_rdata) | 64'(a_faddr) | 64'(a_baddr) | 64'(a_bwdata) | 64'(a_sel), 64'd0);
    check("reset.ctl64", 64'({b_stall, b_rv, b_rw, b_ev, b_breq, b_bwe}), 64'd0);
    check("reset.dat64", 64'(b_rwd) | 64'(b_code) | b_rdata | 64'(b_faddr) | 64'(b_baddr) | b_bwdata | 64'(b_sel), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].w64, tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
              5'(i + 3), tbl[i].ack_at, tbl[i].err);
      compare_obs($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, 5'(i + 3), tbl[i].e_bus, tbl[i].e_stall,
                  tbl[i].e_code, tbl[i].e_baddr, tbl[i].e_sel, tbl[i].e_wdata, tbl[i].e_rdata, tbl[i].e_resp);
    end

    // Reset in the middle of a 64-bit load aborts it silently.
    use64 = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h104;
    req_wdata = 64'd0; req_wd = 5'd9; bus_rdata = 64'h0123456789ABCDEF; req_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("abort.busy", 64'(o_breq), 64'd1);
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("abort.breq", 64'(o_breq), 64'd0);
    check("abort.stall", 64'(o_stall), 64'd0);
    rst = 1'b0; bus_ack = 1'b1;
    quiet = 0;
    for (int c = 0; c < 4; c++) begin
      if (o_rv || o_ev) quiet++;
      @(negedge clk);
      #1;
    end
    check("abort.no_pulse", 64'(quiet), 64'd0);
    bus_ack = 1'b0;
    @(negedge clk);
    run_txn(1, 0, 2'd2, 0, 32'h104, 64'd0, 64'h0123456789ABCDEF, 5'd9, 2, 0);
    compare_obs("recover", 0, 32'h104, 5'd9, 2, 3, 0, 32'h100, 8'h0F, 64'd0, 64'h89ABCDEF, 1);

    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1)); sgn = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3)); sb = 1 << size;
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(sb - 1);
      wdata = {$urandom, $urandom}; rdata = {$urandom, $urandom};
      wd = 5'($urandom_range(0, 31));
      ack_at = $urandom_range(1, TMO + 2);
      err = ($urandom_range(0, 7) == 0);
      if (!w) begin wdata[63:32] = 32'd0; rdata[63:32] = 32'd0; end
      run_txn(w, we, size, sgn, addr, wdata, rdata, wd, ack_at, err);
      model(w, we, size, sgn, addr, wdata, rdata, ack_at, err,
            e_bus, e_stall, e_code, e_baddr, e_sel, e_wdata, e_rdata, e_resp);
      compare_obs($sformatf("rnd%0d", i), we, addr, wd, e_bus, e_stall, e_code, e_baddr, e_sel, e_wdata, e_rdata, e_resp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
